// File: rtl/mmcm_drp_reconfig.sv
// DRP sequencer that reprograms an MMCME2_ADV from a stored profile table.
// Each entry is applied by read-modify-write while the MMCM is held in reset; re-lock is then supervised.
module mmcm_drp_reconfig #(
    parameter int NUM_PROFILES = 4,
    parameter int NUM_REGS     = 23,
    parameter int DRDY_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PW           = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    parameter int IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          dclk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_profile,
    input  logic [IW-1:0] cfg_index,
    input  logic [6:0]    cfg_addr,
    input  logic [15:0]   cfg_mask,
    input  logic [15:0]   cfg_data,
    input  logic          start,
    input  logic [PW-1:0] profile_sel,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [6:0]    drp_daddr,
    output logic          drp_den,
    output logic          drp_dwe,
    output logic [15:0]   drp_di,
    input  logic [15:0]   drp_do,
    input  logic          drp_drdy,
    output logic          mmcm_rst,
    input  logic          locked
);

    localparam int DEPTH = NUM_PROFILES * NUM_REGS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX  = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW    = $clog2(TMAX + 1);

    localparam logic [PW:0]    PROF_LIM  = (PW + 1)'(NUM_PROFILES);
    localparam logic [IW:0]    REG_LIM   = (IW + 1)'(NUM_REGS);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_REGS - 1);
    localparam logic [AW-1:0]  REGS_A    = AW'(NUM_REGS);
    localparam logic [CW-1:0]  DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]  LOCK_SKIP = CW'(2);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] RST_ON    = 4'd1;
    localparam logic [3:0] RD        = 4'd2;
    localparam logic [3:0] RD_WAIT   = 4'd3;
    localparam logic [3:0] WR        = 4'd4;
    localparam logic [3:0] WR_WAIT   = 4'd5;
    localparam logic [3:0] RST_OFF   = 4'd6;
    localparam logic [3:0] LOCK_WAIT = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;
    localparam logic [3:0] FAIL      = 4'd9;

    logic [3:0]    state_reg;
    logic [PW-1:0] prof_reg;
    logic [IW-1:0] idx_reg;
    logic [IW-1:0] idx_next;
    logic [CW-1:0] cnt_reg;
    logic [15:0]   new_reg;
    logic          error_reg;
    logic [1:0]    err_code_reg;

    // Entry layout: {addr[38:32], mask[31:16], data[15:0]}
    logic [38:0]   mem [DEPTH];
    logic [38:0]   rd_entry;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          sel_ok;

    assign sel_ok  = {1'b0, profile_sel} < PROF_LIM;
    assign wr_en   = cfg_we && (state_reg == IDLE) &&
                     ({1'b0, cfg_profile} < PROF_LIM) && ({1'b0, cfg_index} < REG_LIM);
    assign wr_addr = AW'(cfg_profile) * REGS_A + AW'(cfg_index);

    // Addressing by the next index makes rd_entry valid in the cycle the index takes effect.
    always_comb begin
        idx_next = idx_reg;
        if (state_reg == IDLE)
            idx_next = '0;
        else if (state_reg == WR_WAIT && drp_drdy && idx_reg != LAST_IDX)
            idx_next = idx_reg + 1'b1;
    end

    assign rd_addr = AW'(prof_reg) * REGS_A + AW'(idx_next);

    always_ff @(posedge dclk) begin
        if (wr_en)
            mem[wr_addr] <= {cfg_addr, cfg_mask, cfg_data};
        rd_entry <= mem[rd_addr];
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            prof_reg     <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            new_reg      <= '0;
            error_reg    <= 1'b0;
            err_code_reg <= 2'd0;
        end else begin
            idx_reg <= idx_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            error_reg    <= 1'b0;
                            err_code_reg <= 2'd0;
                            prof_reg     <= profile_sel;
                            state_reg    <= RST_ON;
                        end else begin
                            error_reg    <= 1'b1;
                            err_code_reg <= 2'd1;
                            state_reg    <= FAIL;
                        end
                    end
                end
                RST_ON: state_reg <= RD;
                RD: begin
                    cnt_reg   <= '0;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (drp_drdy) begin
                        new_reg   <= (drp_do & rd_entry[31:16]) | (rd_entry[15:0] & ~rd_entry[31:16]);
                        state_reg <= WR;
                    end else if (cnt_reg == DRDY_LAST) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= 2'd2;
                        state_reg    <= FAIL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WR: begin
                    cnt_reg   <= '0;
                    state_reg <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (drp_drdy) begin
                        state_reg <= (idx_reg == LAST_IDX) ? RST_OFF : RD;
                    end else if (cnt_reg == DRDY_LAST) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= 2'd2;
                        state_reg    <= FAIL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RST_OFF: begin
                    cnt_reg   <= '0;
                    state_reg <= LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    // A stale locked from before the reset pulse is not trusted for two cycles.
                    if (locked && cnt_reg >= LOCK_SKIP) begin
                        state_reg <= DONE;
                    end else if (cnt_reg == LOCK_LAST) begin
                        error_reg    <= 1'b1;
                        err_code_reg <= 2'd3;
                        state_reg    <= FAIL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                FAIL:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign error     = error_reg;
    assign err_code  = err_code_reg;
    assign drp_den   = (state_reg == RD) || (state_reg == WR);
    assign drp_dwe   = (state_reg == WR);
    assign drp_daddr = drp_den ? rd_entry[38:32] : 7'd0;
    assign drp_di    = drp_dwe ? new_reg : 16'd0;
    assign mmcm_rst  = (state_reg >= RST_ON) && (state_reg <= WR_WAIT);

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a behavioural DRP port and MMCM lock model.
module tb_mmcm_drp_reconfig;

    logic        dclk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_profile = '0;
    logic [0:0]  cfg_index = '0;
    logic [6:0]  cfg_addr = '0;
    logic [15:0] cfg_mask = '0;
    logic [15:0] cfg_data = '0;
    logic        start = 1'b0;
    logic [2:0]  profile_sel = '0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'hFFFF;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        locked = 1'b0;

    mmcm_drp_reconfig #(
        .NUM_PROFILES(4), .NUM_REGS(2), .DRDY_TIMEOUT(16), .LOCK_TIMEOUT(64), .PW(3)
    ) dut (
        .dclk(dclk), .reset(reset), .cfg_we(cfg_we), .cfg_profile(cfg_profile),
        .cfg_index(cfg_index), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
        .start(start), .profile_sel(profile_sel), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst),
        .locked(locked)
    );

    always #5 dclk = ~dclk;

    int tests_run = 0;
    int tests_failed = 0;

    int drdy_delay = 2;
    int drop_idx = -1;
    bit lock_en = 1'b1;

    logic [6:0]  tx_addr [64];
    logic        tx_we   [64];
    logic [15:0] tx_di   [64];
    logic        tx_rst  [64];
    int tx_cnt = 0;
    int rd_total = 0;
    int pend = 0;
    int done_cnt = 0;
    int rst_cnt = 0;
    int lk_cnt = 0;

    // DRP slave, transaction log and MMCM lock behaviour.
    always @(posedge dclk) begin
        drp_drdy <= 1'b0;
        if (drp_den) begin
            if (tx_cnt < 64) begin
                tx_addr[tx_cnt] = drp_daddr;
                tx_we[tx_cnt]   = drp_dwe;
                tx_di[tx_cnt]   = drp_di;
                tx_rst[tx_cnt]  = mmcm_rst;
            end
            tx_cnt++;
            if (!drp_dwe) rd_total++;
            if (drp_dwe || rd_total != drop_idx) pend = drdy_delay;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) drp_drdy <= 1'b1;
        end
        if (done) done_cnt++;
        if (mmcm_rst) rst_cnt++;
        if (mmcm_rst) begin
            locked <= 1'b0;
            lk_cnt = 0;
        end else if (lock_en && !locked) begin
            lk_cnt++;
            if (lk_cnt >= 50) locked <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cfg_write(input logic [2:0] p, input logic [0:0] i, input logic [6:0] a,
                             input logic [15:0] m, input logic [15:0] d);
        @(negedge dclk);
        cfg_we = 1'b1; cfg_profile = p; cfg_index = i; cfg_addr = a; cfg_mask = m; cfg_data = d;
        @(negedge dclk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] sel);
        @(negedge dclk);
        start = 1'b1; profile_sel = sel;
        @(negedge dclk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge dclk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_tx(input string tag, input int k, input logic [6:0] a,
                            input logic we, input logic [15:0] di);
        check($sformatf("%s_tx%0d_addr", tag, k), 32'(tx_addr[k]), 32'(a));
        check($sformatf("%s_tx%0d_we", tag, k), 32'(tx_we[k]), 32'(we));
        if (we) check($sformatf("%s_tx%0d_di", tag, k), 32'(tx_di[k]), 32'(di));
        check($sformatf("%s_tx%0d_rst", tag, k), 32'(tx_rst[k]), 32'd1);
    endtask

    task automatic check_p1_seq(input string tag, input int b);
        check({tag, "_ntx"}, 32'(tx_cnt - b), 32'd4);
        check_tx(tag, b + 0, 7'h08, 1'b0, 16'h0000);
        check_tx(tag, b + 1, 7'h08, 1'b1, 16'h1041);
        check_tx(tag, b + 2, 7'h09, 1'b0, 16'h0000);
        check_tx(tag, b + 3, 7'h09, 1'b1, 16'hFC00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, r, n;
        reset = 1'b1;
        repeat (3) @(negedge dclk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_den", 32'(drp_den), 32'd0);
        check("rst_dwe", 32'(drp_dwe), 32'd0);
        check("rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("rst_daddr", 32'(drp_daddr), 32'd0);
        check("rst_di", 32'(drp_di), 32'd0);
        reset = 1'b0;

        cfg_write(3'd1, 1'b0, 7'h08, 16'h1000, 16'h0041);
        cfg_write(3'd1, 1'b1, 7'h09, 16'hFC00, 16'h0000);
        cfg_write(3'd2, 1'b0, 7'h10, 16'h00FF, 16'h1200);
        cfg_write(3'd2, 1'b1, 7'h11, 16'h0000, 16'hBEEF);

        // 1: nominal two-entry profile
        b = tx_cnt; d = done_cnt;
        do_start(3'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1", 400);
        check_p1_seq("t1", b);
        check("t1_done_pulses", 32'(done_cnt - d), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_mmcm_rst", 32'(mmcm_rst), 32'd0);

        // 2: drdy never arrives for the second read
        b = tx_cnt; d = done_cnt;
        drop_idx = rd_total + 2;
        do_start(3'd1);
        wait_idle("t2", 400);
        drop_idx = -1;
        check("t2_error", 32'(error), 32'd1);
        check("t2_err_code", 32'(err_code), 32'd2);
        check("t2_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("t2_done_pulses", 32'(done_cnt - d), 32'd0);
        repeat (20) @(negedge dclk);
        check("t2_ntx", 32'(tx_cnt - b), 32'd3);

        // 3: lock never comes, then a good run clears the error
        b = tx_cnt; d = done_cnt;
        lock_en = 1'b0;
        do_start(3'd1);
        wait_idle("t3", 400);
        check("t3_err_code", 32'(err_code), 32'd3);
        check("t3_error", 32'(error), 32'd1);
        check("t3_done_pulses", 32'(done_cnt - d), 32'd0);
        check("t3_ntx", 32'(tx_cnt - b), 32'd4);
        lock_en = 1'b1;
        d = done_cnt;
        do_start(3'd1);
        check("t3_clr_error", 32'(error), 32'd0);
        check("t3_clr_err_code", 32'(err_code), 32'd0);
        wait_idle("t3b", 400);
        check("t3b_done_pulses", 32'(done_cnt - d), 32'd1);
        check("t3b_error", 32'(error), 32'd0);

        // 4: out-of-range profile
        b = tx_cnt; r = rst_cnt;
        do_start(3'd5);
        check("t4_err_code", 32'(err_code), 32'd1);
        check("t4_error", 32'(error), 32'd1);
        wait_idle("t4", 10);
        check("t4_ntx", 32'(tx_cnt - b), 32'd0);
        check("t4_rst_cycles", 32'(rst_cnt - r), 32'd0);

        // 5: start and cfg_we while busy are ignored
        b = tx_cnt;
        do_start(3'd1);
        repeat (4) @(negedge dclk);
        start = 1'b1; profile_sel = 3'd2;
        cfg_we = 1'b1; cfg_profile = 3'd1; cfg_index = 1'b0;
        cfg_addr = 7'h20; cfg_mask = 16'h0000; cfg_data = 16'h0000;
        @(negedge dclk);
        start = 1'b0; cfg_we = 1'b0;
        wait_idle("t5", 400);
        check_p1_seq("t5", b);
        b = tx_cnt;
        do_start(3'd1);
        wait_idle("t5b", 400);
        check_p1_seq("t5b", b);
        b = tx_cnt;
        do_start(3'd2);
        wait_idle("t5c", 400);
        check("t5c_ntx", 32'(tx_cnt - b), 32'd4);
        check_tx("t5c", b + 1, 7'h10, 1'b1, 16'h12FF);
        check_tx("t5c", b + 3, 7'h11, 1'b1, 16'hBEEF);

        // 6: asynchronous reset during WR_WAIT, then a clean rerun
        drdy_delay = 5;
        do_start(3'd1);
        n = 0;
        while (!(drp_den && drp_dwe) && n < 200) begin
            @(negedge dclk);
            n++;
        end
        check("t6_saw_wr", 32'(drp_den && drp_dwe), 32'd1);
        @(negedge dclk);
        #2 reset = 1'b1;
        #1;
        check("t6_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_den", 32'(drp_den), 32'd0);
        repeat (3) @(negedge dclk);
        reset = 1'b0;
        drdy_delay = 2;
        repeat (10) @(negedge dclk);
        b = tx_cnt; d = done_cnt;
        do_start(3'd1);
        wait_idle("t6b", 400);
        check_p1_seq("t6b", b);
        check("t6b_done_pulses", 32'(done_cnt - d), 32'd1);
        check("t6b_error", 32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
